dft_bin_power_det: RTL and testbench



---
 rtl/dft_bin_power_det.sv | 117 +++++++++++
 tb/tb_dft_bin_power_det.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dft_bin_power_det.sv
// Power detector for a single DFT bin: |X|^2 in two pipeline stages, block
// averaging over 2^AVG_SHIFT bins, and a tone-present flag with hysteresis.
module dft_bin_power_det #(
  parameter int W         = 16,
  parameter int AVG_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bin_valid,
  input  logic signed [W-1:0]    bin_re,
  input  logic signed [W-1:0]    bin_im,
  input  logic                   clr,
  input  logic [2*W-1:0]         thr_on,
  input  logic [2*W-1:0]         thr_off,
  output logic                   pwr_valid,
  output logic [2*W-1:0]         pwr,
  output logic                   avg_valid,
  output logic [2*W-1:0]         avg_pwr,
  output logic                   detect,
  output logic [AVG_SHIFT:0]     blk_cnt
);

  localparam int PW = 2 * W;
  localparam int AW = PW + AVG_SHIFT;
  localparam int CW = AVG_SHIFT + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_SHIFT) - 1);

  typedef enum logic {ACCUM, DUMP} state_e;

  // ---------------- squaring / power pipeline ----------------
  logic signed [PW-1:0] re_sq, im_sq;
  logic [PW-1:0]        sq_re_q, sq_im_q;
  logic                 s1_vld_q;
  logic [PW-1:0]        pwr_q;
  logic                 pwr_vld_q;

  assign re_sq = bin_re * bin_re;
  assign im_sq = bin_im * bin_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_re_q   <= '0;
      sq_im_q   <= '0;
      s1_vld_q  <= 1'b0;
      pwr_q     <= '0;
      pwr_vld_q <= 1'b0;
    end else begin
      // clr flushes both stages; a bin arriving with clr is dropped
      s1_vld_q  <= bin_valid & ~clr;
      pwr_vld_q <= s1_vld_q & ~clr;
      if (bin_valid && !clr) begin
        sq_re_q <= re_sq;
        sq_im_q <= im_sq;
      end
      if (s1_vld_q && !clr) pwr_q <= sq_re_q + sq_im_q;
    end
  end

  // ---------------- block averaging ----------------
  state_e         state_q;
  logic [AW-1:0]  acc_q;
  logic [AW-1:0]  acc_base;
  logic [AW-1:0]  sum_d;
  logic [PW-1:0]  avg_d;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  avg_q;
  logic           avg_vld_q;
  logic           det_q;

  // In DUMP the stored sum is stale; a coincident power starts a fresh average.
  always_comb begin
    acc_base = (state_q == DUMP) ? '0 : acc_q;
    sum_d    = acc_base + AW'(pwr_q);
    avg_d    = PW'(sum_d >> AVG_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      det_q     <= 1'b0;
    end else begin
      avg_vld_q <= 1'b0;
      state_q   <= ACCUM;
      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
        det_q <= 1'b0;
      end else if (pwr_vld_q) begin
        if (cnt_q == LAST) begin
          avg_q     <= avg_d;
          avg_vld_q <= 1'b1;
          state_q   <= DUMP;
          cnt_q     <= '0;
          if (!det_q && avg_d >= thr_on)      det_q <= 1'b1;
          else if (det_q && avg_d < thr_off)  det_q <= 1'b0;
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (state_q == DUMP) begin
        acc_q <= '0;
      end
    end
  end

  assign pwr_valid = pwr_vld_q;
  assign pwr       = pwr_q;
  assign avg_valid = avg_vld_q;
  assign avg_pwr   = avg_q;
  assign detect    = det_q;
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_dft_bin_power_det.sv
// Bench for dft_bin_power_det: two instances (AVG_SHIFT=0 and 2) checked every
// cycle against an event-queue model, plus hand-computed literal checks.
module tb_dft_bin_power_det;
  localparam int W  = 16;
  localparam int PW = 2 * W;

  logic clk = 0, rst_n = 0, bin_valid = 0, clr = 0;
  logic signed [W-1:0] bin_re = 0, bin_im = 0;
  logic [PW-1:0] thr_on = 0, thr_off = 0;

  logic          pv0, av0, dt0, pv2, av2, dt2;
  logic [PW-1:0] pw0, ap0, pw2, ap2;
  logic [0:0]    bc0;
  logic [2:0]    bc2;

  int total = 0, bad = 0;
  longint last_avg2 = -1;

  dft_bin_power_det #(.W(W), .AVG_SHIFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bin_valid(bin_valid), .bin_re(bin_re), .bin_im(bin_im),
    .clr(clr), .thr_on(thr_on), .thr_off(thr_off), .pwr_valid(pv0), .pwr(pw0),
    .avg_valid(av0), .avg_pwr(ap0), .detect(dt0), .blk_cnt(bc0));

  dft_bin_power_det #(.W(W), .AVG_SHIFT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bin_valid(bin_valid), .bin_re(bin_re), .bin_im(bin_im),
    .clr(clr), .thr_on(thr_on), .thr_off(thr_off), .pwr_valid(pv2), .pwr(pw2),
    .avg_valid(av2), .avg_pwr(ap2), .detect(dt2), .blk_cnt(bc2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Each accepted bin is scheduled to appear as a power one cycle after the
  // edge that sampled it plus one; clr discards everything still scheduled.
  typedef struct { int due; longint pw; } ev_t;
  ev_t    q[$];
  int     cyc = 0;
  bit     e_pv = 0;
  longint e_pwr = 0;
  longint acc[2] = '{0, 0};
  int     k[2] = '{0, 0};
  longint e_avg[2] = '{0, 0};
  bit     e_av[2] = '{0, 0};
  bit     e_det[2] = '{0, 0};
  int     sh[2] = '{0, 2};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); cyc = 0; e_pv = 0; e_pwr = 0;
      for (int j = 0; j < 2; j++) begin
        acc[j] = 0; k[j] = 0; e_avg[j] = 0; e_av[j] = 0; e_det[j] = 0;
      end
    end else begin
      cyc++;
      for (int j = 0; j < 2; j++) begin
        e_av[j] = 0;
        if (clr) begin
          acc[j] = 0; k[j] = 0; e_det[j] = 0;
        end else if (e_pv) begin
          acc[j] += e_pwr;
          k[j]++;
          if (k[j] == (1 << sh[j])) begin
            e_avg[j] = acc[j] >> sh[j];
            e_av[j]  = 1;
            if (!e_det[j] && e_avg[j] >= longint'(thr_on)) e_det[j] = 1;
            else if (e_det[j] && e_avg[j] < longint'(thr_off)) e_det[j] = 0;
            acc[j] = 0; k[j] = 0;
          end
        end
      end
      if (clr) q.delete();
      e_pv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_pv = 1; e_pwr = q[0].pw; void'(q.pop_front());
      end
      if (bin_valid && !clr)
        q.push_back('{cyc + 1, longint'(bin_re) * longint'(bin_re) + longint'(bin_im) * longint'(bin_im)});
    end
  end

  always @(negedge clk) begin
    chk("pv0", pv0, e_pv);        chk("pw0", pw0, e_pwr);
    chk("av0", av0, e_av[0]);     chk("ap0", ap0, e_avg[0]);
    chk("dt0", dt0, e_det[0]);    chk("bc0", bc0, k[0]);
    chk("pv2", pv2, e_pv);        chk("pw2", pw2, e_pwr);
    chk("av2", av2, e_av[1]);     chk("ap2", ap2, e_avg[1]);
    chk("dt2", dt2, e_det[1]);    chk("bc2", bc2, k[1]);
    if (!rst_n) last_avg2 = -1;
    else if (av2) last_avg2 = ap2;
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) tick(); endtask
  task automatic bin(input int r, input int i);
    bin_valid = 1; bin_re = W'(r); bin_im = W'(i); tick(); bin_valid = 0;
  endtask
  task automatic pulse_clr(); clr = 1; tick(); clr = 0; endtask
  task automatic group(input int r, input int i);
    repeat (4) bin(r, i);
    idle(4);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwr", pw2, 0);  chk("rst_avg", ap2, 0);
    chk("rst_det", dt2, 0);  chk("rst_cnt", bc2, 0);
    rst_n = 1;
    idle(2);

    // single bin latency on AVG_SHIFT=0
    bin(3, 4);
    tick();
    chk("lat_pv", pv0, 1);   chk("lat_pw", pw0, 25);
    tick();
    chk("lat_av", av0, 1);   chk("lat_ap", ap0, 25);
    idle(2); pulse_clr(); idle(3);

    // extreme inputs, no wrap
    bin(-32768, -32768);
    bin(32767, -32768);
    chk("max_pw", pw0, 64'h8000_0000);
    tick();
    chk("max2_pw", pw0, 2147418113);
    idle(3); pulse_clr(); idle(3);

    // averaging and carry into next block: 100,200,250,450 -> 250
    bin(10, 0); bin(10, 10); bin(15, 5); bin(15, 15); bin(3, 1);
    idle(4);
    chk("avg250", last_avg2, 250);
    chk("cnt_next", bc2, 1);
    pulse_clr(); idle(3);
    bin(1, 0); bin(1, 0); bin(1, 0); bin(1, 1);
    idle(4);
    chk("avg_trunc", last_avg2, 1);
    chk("cnt_zero", bc2, 0);

    // hysteresis
    thr_on = 1000; thr_off = 500;
    pulse_clr(); idle(3);
    group(25, 25); chk("hy1250", dt2, 1); chk("hy_avg", last_avg2, 1250);
    group(26, 0);  chk("hy676", dt2, 1);
    group(20, 0);  chk("hy400", dt2, 0);
    group(30, 0);  chk("hy900", dt2, 0);
    group(30, 10); chk("hy1000", dt2, 1);
    group(20, 10); chk("hy500", dt2, 1);

    // clr discards partial average
    pulse_clr(); idle(3);
    bin(50, 50); bin(50, 50); bin(50, 50);
    pulse_clr();
    group(10, 0);
    chk("clr_avg", last_avg2, 100);
    chk("clr_det", dt2, 0);
    idle(2);
    clr = 1; bin(50, 50); clr = 0;
    group(8, 0);
    chk("clrbin_avg", last_avg2, 64);
    chk("clrbin_det", dt2, 0);

    // reset mid-average
    idle(3);
    bin(50, 50); bin(50, 50);
    idle(3);
    rst_n = 0;
    #1;
    chk("mr_pv", pv2, 0);  chk("mr_pw", pw2, 0);
    chk("mr_av", av2, 0);  chk("mr_ap", ap2, 0);
    chk("mr_dt", dt2, 0);  chk("mr_cnt", bc2, 0);
    @(negedge clk);
    #2 rst_n = 1;
    tick();
    bin(8, 0); bin(8, 0);
    idle(3);
    chk("mr_part", bc2, 2);
    bin(8, 0); bin(8, 0);
    idle(4);
    chk("mr_avg", last_avg2, 64);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
